ct_had_pcfifo_nway: RTL

Parametrised HAD trace PC FIFO. It captures the next-PC of every change-of-flow instruction retired by the RTU, up to LANES per cycle, and compacts them in lane order into a circular buffer of DEPTH entries. When full, the oldest entries are overwritten. The debugger reads the buffer one entry at a time through the HAD register file. Compared with the fixed 3/4-lane version it adds occupancy reporting, overflow/lost-entry accounting and a synchronous clear.

---
 rtl/ct_had_pcfifo_nway_pkg.sv | 18 +
 rtl/ct_had_pcfifo_nway_if.sv | 36 +++
 rtl/ct_had_pcfifo_nway_compact.sv | 21 ++
 rtl/ct_had_pcfifo_nway.sv | 110 +++++++++++
 4 files changed

// File: rtl/ct_had_pcfifo_nway_pkg.sv
// Shared HAD trace PC FIFO defaults and the saturating lost-entry adder.
package ct_had_pcfifo_nway_pkg;
  localparam int PCFIFO_PA_WIDTH = 40;
  localparam int PCFIFO_LANES    = 4;
  localparam int PCFIFO_DEPTH    = 16;
  localparam int PCFIFO_PC_W     = PCFIFO_PA_WIDTH - 1;
  localparam int PCFIFO_DATAW    = 64;
  localparam int PCFIFO_LOST_W   = 8;

  function automatic logic [PCFIFO_LOST_W-1:0] lost_sat_add(
    input logic [PCFIFO_LOST_W-1:0] cur,
    input logic [PCFIFO_LOST_W-1:0] inc
  );
    logic [PCFIFO_LOST_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return sum[PCFIFO_LOST_W] ? {PCFIFO_LOST_W{1'b1}} : sum[PCFIFO_LOST_W-1:0];
  endfunction
endpackage

// File: rtl/ct_had_pcfifo_nway_if.sv
// Capture/pop controls and register-file view of the trace PC FIFO.
interface ct_had_pcfifo_nway_if #(
  parameter int LANES = ct_had_pcfifo_nway_pkg::PCFIFO_LANES,
  parameter int DEPTH = ct_had_pcfifo_nway_pkg::PCFIFO_DEPTH,
  parameter int PC_W  = ct_had_pcfifo_nway_pkg::PCFIFO_PC_W,
  parameter int DATAW = ct_had_pcfifo_nway_pkg::PCFIFO_DATAW
);
  import ct_had_pcfifo_nway_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     ctrl_pcfifo_wen;
  logic                     ctrl_pcfifo_ren;
  logic                     ctrl_pcfifo_clr;
  logic                     mmu_xx_mmu_en;
  logic [LANES-1:0]         rtu_had_xx_pcfifo_chgflow;
  logic [LANES*PC_W-1:0]    rtu_had_xx_pcfifo_next_pc;
  logic [DATAW-1:0]         pcfifo_regs_data;
  logic [CNT_W-1:0]         pcfifo_regs_cnt;
  logic                     pcfifo_regs_empty;
  logic                     pcfifo_regs_ovf;
  logic [PCFIFO_LOST_W-1:0] pcfifo_regs_lost;

  modport master (
    output ctrl_pcfifo_wen, ctrl_pcfifo_ren, ctrl_pcfifo_clr, mmu_xx_mmu_en,
           rtu_had_xx_pcfifo_chgflow, rtu_had_xx_pcfifo_next_pc,
    input  pcfifo_regs_data, pcfifo_regs_cnt, pcfifo_regs_empty,
           pcfifo_regs_ovf, pcfifo_regs_lost
  );

  modport slave (
    input  ctrl_pcfifo_wen, ctrl_pcfifo_ren, ctrl_pcfifo_clr, mmu_xx_mmu_en,
           rtu_had_xx_pcfifo_chgflow, rtu_had_xx_pcfifo_next_pc,
    output pcfifo_regs_data, pcfifo_regs_cnt, pcfifo_regs_empty,
           pcfifo_regs_ovf, pcfifo_regs_lost
  );
endinterface

// File: rtl/ct_had_pcfifo_nway_compact.sv
// Lane compaction: per-lane prefix popcount of lower valid lanes, plus total.
module ct_had_pcfifo_compact #(
  parameter int LANES = ct_had_pcfifo_nway_pkg::PCFIFO_LANES,
  parameter int OW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]    i_vld,
  output logic [LANES*OW-1:0] o_off,
  output logic [OW-1:0]       o_k
);
  logic [OW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    o_off = '0;
    for (int i = 0; i < LANES; i++) begin
      o_off[i*OW +: OW] = w_acc;
      w_acc = w_acc + OW'(i_vld[i]);
    end
    o_k = w_acc;
  end
endmodule

// File: rtl/ct_had_pcfifo_nway.sv
// HAD trace PC FIFO: compacts up to LANES change-of-flow PCs per cycle into a
// circular buffer that overwrites its oldest entries when full.
module ct_had_pcfifo_nway #(
  parameter int LANES = ct_had_pcfifo_nway_pkg::PCFIFO_LANES,
  parameter int DEPTH = ct_had_pcfifo_nway_pkg::PCFIFO_DEPTH,
  parameter int PC_W  = ct_had_pcfifo_nway_pkg::PCFIFO_PC_W,
  parameter int DATAW = ct_had_pcfifo_nway_pkg::PCFIFO_DATAW
) (
  input logic                 cpuclk,
  input logic                 cpurst_b,
  ct_had_pcfifo_nway_if.slave bus
);
  import ct_had_pcfifo_nway_pkg::*;

  localparam int EW = PC_W + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(LANES + 1);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [LANES-1:0]         r_chg_q;
  logic                     r_wen_q;
  logic [EW-1:0]            r_pc_q [LANES];
  logic [EW-1:0]            r_mem  [DEPTH];
  logic [AW-1:0]            r_wptr;
  logic [AW-1:0]            r_rptr;
  logic [CW-1:0]            r_cnt;
  logic                     r_ovf;
  logic [PCFIFO_LOST_W-1:0] r_lost;
  logic [EW-1:0]            r_dout;

  logic [LANES*OW-1:0] w_off;
  logic [OW-1:0]       w_k_raw;
  logic [CW:0]         w_k;
  logic [CW:0]         w_base;
  logic [CW:0]         w_tot;
  logic [CW:0]         w_drop;
  logic                w_wr;
  logic                w_rd;

  ct_had_pcfifo_compact #(.LANES(LANES), .OW(OW)) u_compact (
    .i_vld (r_chg_q),
    .o_off (w_off),
    .o_k   (w_k_raw)
  );

  // Clear wins over both the S2 write and the pop of the same cycle.
  assign w_wr   = r_wen_q & ~bus.ctrl_pcfifo_clr;
  assign w_rd   = bus.ctrl_pcfifo_ren & (r_cnt != '0) & ~bus.ctrl_pcfifo_clr;
  assign w_k    = w_wr ? (CW+1)'(w_k_raw) : '0;
  assign w_base = {1'b0, r_cnt} - (CW+1)'(w_rd);
  assign w_tot  = w_base + w_k;
  assign w_drop = (w_tot > DEPTH_V) ? (w_tot - DEPTH_V) : '0;

  // S1: PCs held only for valid lanes
  always_ff @(posedge cpuclk) begin
    for (int i = 0; i < LANES; i++) begin
      if (bus.rtu_had_xx_pcfifo_chgflow[i])
        r_pc_q[i] <= {bus.rtu_had_xx_pcfifo_next_pc[i*PC_W +: PC_W], 1'b0};
    end
  end

  // S2: valid lanes stored contiguously from wptr, wrapping modulo DEPTH
  always_ff @(posedge cpuclk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_wr && r_chg_q[i])
        r_mem[r_wptr + AW'(w_off[i*OW +: OW])] <= r_pc_q[i];
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_chg_q <= '0;
      r_wen_q <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_lost  <= '0;
      r_dout  <= '0;
    end else begin
      r_wen_q <= bus.ctrl_pcfifo_wen;
      r_chg_q <= bus.ctrl_pcfifo_clr ? '0 : bus.rtu_had_xx_pcfifo_chgflow;
      if (w_rd)
        r_dout <= r_mem[r_rptr];
      if (bus.ctrl_pcfifo_clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        r_lost <= '0;
      end else begin
        // Overwritten oldest entries are skipped by advancing rptr past them.
        r_wptr <= r_wptr + AW'(w_k);
        r_rptr <= r_rptr + AW'(w_rd) + AW'(w_drop);
        r_cnt  <= (w_tot > DEPTH_V) ? DEPTH_V[CW-1:0] : w_tot[CW-1:0];
        if (w_drop != '0) begin
          r_ovf  <= 1'b1;
          r_lost <= lost_sat_add(r_lost, PCFIFO_LOST_W'(w_drop));
        end
      end
    end
  end

  assign bus.pcfifo_regs_data  = {{(DATAW-EW){bus.mmu_xx_mmu_en & r_dout[EW-1]}}, r_dout};
  assign bus.pcfifo_regs_cnt   = r_cnt;
  assign bus.pcfifo_regs_empty = (r_cnt == '0);
  assign bus.pcfifo_regs_ovf   = r_ovf;
  assign bus.pcfifo_regs_lost  = r_lost;
endmodule
